// File: rtl/cv_clock_pkg.sv
// Shared constants and per-channel state record for the clock-enable generator.
// Counter fields are sized for the widest supported divisor; narrower builds zero-extend.
package cv_clock_pkg;

  localparam int CNT_W_DEF   = 4;
  localparam int DIV_RST_DEF = 3;
  localparam int CNT_MAX_W   = 8;

  typedef logic [CNT_MAX_W-1:0] cnt_t;

  localparam cnt_t CNT_ZERO = '0;
  localparam cnt_t CNT_ONE  = cnt_t'(1);

  typedef struct packed {
    cnt_t d;
    cnt_t p;
    cnt_t c;
    logic pend;
  } ch_state_t;

  // A stopped channel (divisor 0) parks its counter at 0 instead of wrapping to all-ones.
  function automatic cnt_t reload_cnt(input cnt_t d_new);
    return (d_new == CNT_ZERO) ? CNT_ZERO : (d_new - CNT_ONE);
  endfunction

endpackage

// File: rtl/cv_clock_ch.sv
// One clock-enable channel: active/pending divisor, down-counter and phase enables.
// Pending divisors only land at a period wrap or on sync, so a running period is never cut short.
module cv_clock_ch
  import cv_clock_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             base,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             pend,
  output logic             en_p,
  output logic             en_n
);

  ch_state_t st;
  cnt_t      d_new;
  logic      wrap;

  assign d_new = st.pend ? st.p : st.d;
  assign wrap  = base && (st.c == CNT_ZERO);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      st.d    <= cnt_t'(DIV_RST);
      st.p    <= cnt_t'(DIV_RST);
      st.c    <= CNT_ZERO;
      st.pend <= 1'b0;
    end else begin
      if (sync || wrap) begin
        st.d    <= d_new;
        st.c    <= reload_cnt(d_new);
        st.pend <= 1'b0;
      end else if (base) begin
        st.c <= st.c - CNT_ONE;
      end
      // A load on the wrap edge overrides the pend clear: old P applies, new P waits.
      if (load) begin
        st.p    <= cnt_t'(load_div);
        st.pend <= 1'b1;
      end
    end
  end

  assign pend = st.pend;
  assign en_p = base && (st.c == CNT_ZERO) && (st.d != CNT_ZERO);
  assign en_n = base && (st.c == (st.d - CNT_ONE)) && (st.d != CNT_ZERO);

endmodule

// File: rtl/cv_clock_gen.sv
// Multi-channel clock-enable generator: decodes divisor loads per channel and
// fans the shared base tick and sync pulse out to every channel.
module cv_clock_gen
  import cv_clock_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clk_en_base_i,
  input  logic              sync_i,
  input  logic              load_i,
  input  logic [CH_W-1:0]   load_ch_i,
  input  logic [CNT_W-1:0]  load_div_i,
  output logic [NUM_CH-1:0] pend_o,
  output logic [NUM_CH-1:0] en_p_o,
  output logic [NUM_CH-1:0] en_n_o
);

  logic [NUM_CH-1:0] load_sel;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // Out-of-range channel numbers match no k and are dropped here.
    assign load_sel[k] = load_i && (int'(load_ch_i) == k);

    cv_clock_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .base      (clk_en_base_i),
      .sync      (sync_i),
      .load      (load_sel[k]),
      .load_div  (load_div_i),
      .pend      (pend_o[k]),
      .en_p      (en_p_o[k]),
      .en_n      (en_n_o[k])
    );
  end

endmodule
